// File: rtl/seven_segment_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with blanking gaps and frame-synchronous shadow loading.
// Optional leading-zero suppression is enabled by defining SSD_LEADING_ZERO_BLANK_EN.
module seven_segment_scan_ctrl #(
  parameter int CLKS_PER_DIGIT = 100000,
  parameter int DEAD_CLKS      = 16
) (
  input  logic       i_CLK,
  input  logic       i_RESET,
  input  logic       i_ENABLE,
  input  logic       i_LOAD,
  input  logic [3:0] i_DIGIT_1,
  input  logic [3:0] i_DIGIT_2,
  input  logic [3:0] i_DIGIT_3,
  input  logic [3:0] i_DIGIT_4,
  output logic [3:0] o_OUT,
  output logic [3:0] o_ANODES,
  output logic       o_PENDING,
  output logic       o_FRAME
);

  // One counter serves both phases and is wide enough for the largest legal digit time.
  localparam int              CNT_W     = 20;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(CLKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CLKS - 1);

  typedef enum logic [0:0] {
    ST_DEAD = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_index;
  logic [1:0]       w_index_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_wrap;

  // Element 0 holds digit 1 (leftmost).
  logic [3:0][3:0]  r_shadow;
  logic [3:0][3:0]  w_shadow_nxt;
  logic [3:0][3:0]  r_display;
  logic [3:0][3:0]  w_display_nxt;
  logic             r_pending;
  logic             w_pending_nxt;
  logic             w_xfer;
  logic             w_blank;

  logic [3:0]       r_out;
  logic [3:0]       w_out_nxt;
  logic [3:0]       r_anodes;
  logic [3:0]       w_anodes_nxt;
  logic             r_frame;
  logic             w_frame_nxt;

`ifdef SSD_LEADING_ZERO_BLANK_EN
  function automatic logic f_lead_zero(input logic [3:0][3:0] disp, input logic [1:0] idx);
    logic res;
    case (idx)
      2'd0:    res = (disp[0] == 4'd0);
      2'd1:    res = (disp[0] == 4'd0) && (disp[1] == 4'd0);
      2'd2:    res = (disp[0] == 4'd0) && (disp[1] == 4'd0) && (disp[2] == 4'd0);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign w_blank = f_lead_zero(w_display_nxt, w_index_nxt);
`else
  assign w_blank = 1'b0;
`endif

  // Scan state register.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_state <= ST_DEAD;
      r_index <= 2'd0;
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state logic: a disabled display parks in the restart position.
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_count_nxt = r_count;
    w_wrap      = 1'b0;
    if (!i_ENABLE) begin
      w_state_nxt = ST_DEAD;
      w_index_nxt = 2'd0;
      w_count_nxt = {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_DEAD: begin
          if (r_count == DEAD_LAST) begin
            w_state_nxt = ST_SHOW;
            w_count_nxt = {CNT_W{1'b0}};
          end else begin
            w_count_nxt = r_count + 20'd1;
          end
        end
        ST_SHOW: begin
          if (r_count == SHOW_LAST) begin
            w_state_nxt = ST_DEAD;
            w_count_nxt = {CNT_W{1'b0}};
            w_index_nxt = r_index + 2'd1;
            w_wrap      = (r_index == 2'd3);
          end else begin
            w_count_nxt = r_count + 20'd1;
          end
        end
        default: begin
          w_state_nxt = ST_DEAD;
          w_index_nxt = 2'd0;
          w_count_nxt = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Shadow/display handoff: the shadow is applied at the end of the frame-pulse cycle,
  // or at once while disabled since no frame boundary will come.
  always_comb begin
    w_xfer        = r_pending & (r_frame | ~i_ENABLE);
    w_display_nxt = r_display;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;
    if (w_xfer) begin
      w_display_nxt = r_shadow;
      w_pending_nxt = 1'b0;
    end else begin
      w_display_nxt = r_display;
    end
    if (i_LOAD) begin
      w_shadow_nxt  = {i_DIGIT_4, i_DIGIT_3, i_DIGIT_2, i_DIGIT_1};
      w_pending_nxt = 1'b1;
    end else begin
      w_shadow_nxt  = r_shadow;
    end
  end

  // Output decode from next-cycle state so the registered outputs line up with the scan state.
  always_comb begin
    w_out_nxt    = w_display_nxt[w_index_nxt];
    w_frame_nxt  = w_wrap;
    w_anodes_nxt = 4'b1111;
    if ((w_state_nxt == ST_SHOW) && !w_blank) begin
      case (w_index_nxt)
        2'd0:    w_anodes_nxt = 4'b0111;
        2'd1:    w_anodes_nxt = 4'b1011;
        2'd2:    w_anodes_nxt = 4'b1101;
        default: w_anodes_nxt = 4'b1110;
      endcase
    end else begin
      w_anodes_nxt = 4'b1111;
    end
  end

  // Data and output registers.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_shadow  <= {4{4'd0}};
      r_display <= {4{4'd0}};
      r_pending <= 1'b0;
      r_out     <= 4'd0;
      r_anodes  <= 4'b1111;
      r_frame   <= 1'b0;
    end else begin
      r_shadow  <= w_shadow_nxt;
      r_display <= w_display_nxt;
      r_pending <= w_pending_nxt;
      r_out     <= w_out_nxt;
      r_anodes  <= w_anodes_nxt;
      r_frame   <= w_frame_nxt;
    end
  end

  assign o_OUT     = r_out;
  assign o_ANODES  = r_anodes;
  assign o_PENDING = r_pending;
  assign o_FRAME   = r_frame;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Randomized bench for seven_segment_scan_ctrl against a slot-arithmetic reference model.
// Honours SSD_LEADING_ZERO_BLANK_EN in the model when the design is built with it.
module tb_seven_segment_scan_ctrl;

  localparam int CPD       = 4;
  localparam int DC        = 2;
  localparam int SLOT      = CPD + DC;
  localparam int FRAME_LEN = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] d1, d2, d3, d4;
  logic [3:0] out;
  logic [3:0] anodes;
  logic       pending;
  logic       frame;

  seven_segment_scan_ctrl #(
    .CLKS_PER_DIGIT(CPD),
    .DEAD_CLKS     (DC)
  ) dut (
    .i_CLK    (clk),
    .i_RESET  (rst),
    .i_ENABLE (en),
    .i_LOAD   (load),
    .i_DIGIT_1(d1),
    .i_DIGIT_2(d2),
    .i_DIGIT_3(d3),
    .i_DIGIT_4(d4),
    .o_OUT    (out),
    .o_ANODES (anodes),
    .o_PENDING(pending),
    .o_FRAME  (frame)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: m_t counts cycles since the last restart (reset or a disabled cycle).
  int         m_t;
  logic [3:0] m_disp[4];
  logic [3:0] m_shadow[4];
  logic       m_pend;

  task automatic check_eq(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0d, time %0t)", tag, act, exp, m_t, $time);
    end
  endtask

  function automatic int slot_idx();
    return (m_t / SLOT) % 4;
  endfunction

  function automatic bit in_dead();
    return (m_t % SLOT) < DC;
  endfunction

  function automatic logic exp_frame();
    return (m_t > 0) && (m_t % FRAME_LEN == 0);
  endfunction

  function automatic logic [3:0] exp_anodes();
    logic [3:0] a;
    int idx;
    bit lead;
    idx = slot_idx();
    a = 4'b1111;
    if (!in_dead()) a[3 - idx] = 1'b0;
    lead = 1'b1;
    for (int j = 0; j <= idx; j++) if (m_disp[j] != 4'd0) lead = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    if (idx != 3 && lead) a = 4'b1111;
`endif
    return a;
  endfunction

  task automatic model_reset();
    m_t    = 0;
    m_pend = 1'b0;
    for (int j = 0; j < 4; j++) begin
      m_disp[j]   = 4'd0;
      m_shadow[j] = 4'd0;
    end
  endtask

  // Called at a falling edge: compare, drive this cycle's inputs, advance the model, clock once.
  task automatic step(input logic e, input logic l, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    bit fr, xfer;
    check_eq("out",     out,             m_disp[slot_idx()]);
    check_eq("anodes",  anodes,          exp_anodes());
    check_eq("pending", {3'b000, pending}, {3'b000, m_pend});
    check_eq("frame",   {3'b000, frame},   {3'b000, exp_frame()});
    en = e; load = l; d1 = a; d2 = b; d3 = c; d4 = d;
    fr   = exp_frame();
    xfer = m_pend && (fr || !e);
    if (xfer) m_disp = m_shadow;
    if (l) begin
      m_shadow[0] = a; m_shadow[1] = b; m_shadow[2] = c; m_shadow[3] = d;
    end
    m_pend = l ? 1'b1 : (xfer ? 1'b0 : m_pend);
    m_t    = e ? m_t + 1 : 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
  endtask

  // Asserts reset between clock edges, checks the immediate effect, releases at a falling edge.
  task automatic apply_reset(input logic hold_load);
    load = hold_load; d1 = 4'd9; d2 = 4'd9; d3 = 4'd9; d4 = 4'd9;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_anodes",  anodes,            4'b1111);
    check_eq("rst_out",     out,               4'd0);
    check_eq("rst_pending", {3'b000, pending}, 4'd0);
    check_eq("rst_frame",   {3'b000, frame},   4'd0);
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    model_reset();
  endtask

  function automatic logic [3:0] rnd_digit();
    return ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
  endfunction

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0;
    d1 = 4'd0; d2 = 4'd0; d3 = 4'd0; d4 = 4'd0;
    model_reset();
    #1;
    apply_reset(1'b0);

    // Free-running scan from reset: dead/show pattern and frame period.
    idle(2 * FRAME_LEN + 3);

    // Mid-frame load, then a second load exactly on the frame-pulse cycle.
    while ((m_t % FRAME_LEN) != 9) idle(1);
    step(1'b1, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 0; i < 2 * FRAME_LEN && !exp_frame(); i++) idle(1);
    step(1'b1, 1'b1, 4'd5, 4'd6, 4'd7, 4'd8);
    idle(2 * FRAME_LEN + 2);

    // Disable during digit 3 with a load while disabled, then re-enable.
    while (!(slot_idx() == 2 && !in_dead())) idle(1);
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    step(1'b0, 1'b1, 4'd9, 4'd0, 4'd0, 4'd3);
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    idle(FRAME_LEN + 4);

    // Reset during digit 2 with a pending shadow and a load in flight.
    while (!(slot_idx() == 1 && !in_dead())) idle(1);
    step(1'b1, 1'b1, 4'd7, 4'd7, 4'd7, 4'd7);
    apply_reset(1'b1);
    idle(FRAME_LEN + 2);

    // Leading-zero patterns.
    step(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    idle(2 * FRAME_LEN);
    step(1'b1, 1'b1, 4'd0, 4'd0, 4'd5, 4'd0);
    idle(2 * FRAME_LEN);
    step(1'b1, 1'b1, 4'd0, 4'd3, 4'd0, 4'd0);
    idle(2 * FRAME_LEN);

    // Randomized traffic: occasional disables, loads (sometimes back-to-back) and resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset($urandom_range(0, 1) == 1);
      end else begin
        step(($urandom_range(0, 39) != 0), ($urandom_range(0, 14) == 0),
             rnd_digit(), rnd_digit(), rnd_digit(), rnd_digit());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan_ctrl.md
SEVEN_SEGMENT_SCAN_CTRL -- requirements
Module: seven_segment_scan_ctrl

Interface
REQ-001 Parameter CLKS_PER_DIGIT, default 100000, i_CLK cycles each digit is lit; legal range 1..2^20-1.
REQ-002 Parameter DEAD_CLKS, default 16, i_CLK cycles of all-anodes-off blanking before each digit; legal range 1..255.
REQ-003 i_CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 i_RESET  input  1  asynchronous reset, active-high.
REQ-005 i_ENABLE  input  1  scanning enable; low blanks the display.
REQ-006 i_LOAD  input  1  one-cycle strobe capturing i_DIGIT_1..4 into the shadow buffer.
REQ-007 i_DIGIT_1..i_DIGIT_4  input  4 each  new digit values; DIGIT_1 is leftmost (most significant).
REQ-008 o_OUT  output  4  value of the currently scanned digit, registered.
REQ-009 o_ANODES  output  4  active-low anode select, registered; 0111=digit1, 1011=digit2, 1101=digit3, 1110=digit4, 1111=none.
REQ-010 o_PENDING  output  1  high while the shadow buffer holds data not yet applied to the display.
REQ-011 o_FRAME  output  1  one-cycle pulse when the scan index wraps from digit4 to digit1.

Function
REQ-012 The block SHALL implement a two-state FSM: DEAD (anodes 1111) and SHOW (anode of current index low).
REQ-013 DEAD SHALL last exactly DEAD_CLKS cycles, then SHOW SHALL begin for the current index.
REQ-014 SHOW SHALL last exactly CLKS_PER_DIGIT cycles, then the index SHALL increment (3 wraps to 0) and the FSM SHALL enter DEAD.
REQ-015 Full frame period SHALL be 4*(DEAD_CLKS+CLKS_PER_DIGIT) cycles; the duty-cycle counter SHALL be sized for the parameter maximum.
REQ-016 o_OUT SHALL equal the display-register entry for the current index in both states; only o_ANODES blanks in DEAD.
REQ-017 o_FRAME SHALL assert for exactly the one cycle in which the index changes from 3 to 0.
REQ-018 i_LOAD high SHALL capture all four i_DIGIT inputs into the shadow buffer and set o_PENDING the next cycle.
REQ-019 Shadow SHALL transfer into the display register only on the o_FRAME cycle, clearing o_PENDING; no mid-frame tearing.
REQ-020 i_LOAD coinciding with o_FRAME: the previous shadow SHALL be applied, the new data SHALL be captured into shadow, o_PENDING SHALL stay high.
REQ-021 Repeated i_LOAD before transfer SHALL overwrite the shadow; last load wins.
REQ-022 i_ENABLE low SHALL, from the next cycle, force DEAD, anodes 1111, index 0, counter 0, o_FRAME 0.
REQ-023 While i_ENABLE is low, a pending shadow SHALL transfer on the next cycle (no frame boundary exists).
REQ-024 On i_ENABLE rising, the sequence SHALL restart exactly as after reset release (DEAD, index 0).

Reset
REQ-025 i_RESET high SHALL immediately, without a clock edge, set: FSM DEAD, index 0, counter 0, shadow and display registers 0, o_OUT 0000, o_ANODES 1111, o_PENDING 0, o_FRAME 0.
REQ-026 Reset asserted mid-SHOW or mid-load SHALL discard all in-flight state; no partial transfer survives.
REQ-027 After reset release with i_ENABLE high, the first digit1 SHOW cycle SHALL be cycle DEAD_CLKS+1.

Configuration
REQ-028 Macro SSD_LEADING_ZERO_BLANK_EN SHALL control leading-zero suppression.
REQ-029 With SSD_LEADING_ZERO_BLANK_EN defined: during SHOW, the anode of any display digit that is 0 and has only zero digits to its left SHALL stay high; digit4 SHALL never be suppressed; slot timing and o_FRAME SHALL be unchanged.
REQ-030 Without SSD_LEADING_ZERO_BLANK_EN: all four digits SHALL be lit in their SHOW slot regardless of value.

Verification (CLKS_PER_DIGIT=4, DEAD_CLKS=2)
REQ-031 Reset release, i_ENABLE=1 -> anodes 1111 for 2 cycles, 0111 for 4, 1111 for 2, 1011 for 4 ...; o_FRAME period 24 cycles.
REQ-032 i_LOAD with 1,2,3,4 mid-frame -> o_PENDING=1 next cycle; o_OUT unchanged until o_FRAME cycle; then digit slots show 1,2,3,4, o_PENDING=0.
REQ-033 i_LOAD 5,6,7,8 on o_FRAME cycle with shadow 1,2,3,4 pending -> frame shows 1,2,3,4, o_PENDING stays 1, next frame shows 5,6,7,8.
REQ-034 i_ENABLE low during digit3 SHOW -> next cycle anodes 1111, index 0; re-enable -> 2 dead cycles then 0111.
REQ-035 i_RESET pulse mid-digit2 SHOW with pending shadow -> anodes 1111 asynchronously, o_PENDING 0, display 0000 after release.
REQ-036 Macro defined, load 0,0,0,0 -> only 1110 lit; load 0,0,5,0 -> digits 1,2 suppressed, 1101 and 1110 lit; macro undefined -> all four lit.
